// File: rtl/updown_pulse_tx_if.sv
// ----------------------------------------------------------------------------
// updown_pulse_tx_if
// Bundles the command handshake and the pulse-line outputs of updown_pulse_tx.
//   master : command sender (drives cmd_*, abort; observes the rest)
//   slave  : the transmitter (drives up/down lines, status and shadow counters)
// Signals:
//   cmd_valid / cmd_ready   command handshake
//   cmd_dir, cmd_count      1 = pulse `up`, 0 = pulse `down`; number of pulses
//   abort                   stop after the pulse in progress
//   up, down                active-low pulse lines, idle high
//   busy, done              command in progress / one-cycle finish strobe
//   sent, pos               pulses completed / shadow of receiver count
// ----------------------------------------------------------------------------
interface updown_pulse_tx_if #(
    parameter int CNT_W = 14
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic             up;
    logic             down;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;
    logic [CNT_W-1:0] pos;

    modport master (
        output cmd_valid, cmd_dir, cmd_count, abort,
        input  cmd_ready, up, down, busy, done, sent, pos
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_count, abort,
        output cmd_ready, up, down, busy, done, sent, pos
    );
endinterface

// File: rtl/updown_pulse_tx.sv
// ----------------------------------------------------------------------------
// updown_pulse_tx
// Transmit end of the two-wire up/down pulse interface. A command of N steps
// and a direction produces N active-low pulses on `up` or `down`, each
// PULSE_LOW cycles low followed by PULSE_GAP cycles with both lines high.
// A shadow position tracks the value the receiving counter should hold.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    updown_pulse_tx_if.slave (command handshake, abort, pulse lines,
//          busy/done status, sent count and shadow position)
// All outputs are registered so the edge-triggered receiver never sees a
// glitch on `up` or `down`.
// ----------------------------------------------------------------------------
module updown_pulse_tx #(
    parameter int CNT_W     = 14,
    parameter int PULSE_LOW = 4,
    parameter int PULSE_GAP = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_pulse_tx_if.slave      bus
);

    localparam int TMR_MAX = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] LOW_LAST = TMR_W'(PULSE_LOW - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(PULSE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_GAP,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_dir;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_pos;
    logic             r_abort_pend;
    logic             r_up;
    logic             r_down;
    logic             r_busy;
    logic             r_done;
    logic             r_cmd_ready;

    logic             w_accept;
    logic             w_low_end;
    logic             w_dir_eff;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_low_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (bus.cmd_count == '0) ? S_FIN : S_LOW;
                end
            end
            S_LOW: begin
                if (r_timer == LOW_LAST) begin
                    w_low_end    = 1'b1;
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                // r_sent already includes the pulse that just ended. An abort
                // arriving in the final gap cycle also prevents the next pulse.
                if (r_timer == GAP_LAST) begin
                    if ((r_sent == r_count) || r_abort_pend || bus.abort) begin
                        w_next_state = S_FIN;
                    end else begin
                        w_next_state = S_LOW;
                    end
                end
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Direction in force for the next cycle: on acceptance the latched copy
    // is not yet updated, so take it straight from the command.
    assign w_dir_eff = w_accept ? bus.cmd_dir : r_dir;

    // ------------------------------------------------------------------------
    // Datapath: phase timer, command latch, sent/pos counters, abort flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer      <= '0;
            r_dir        <= 1'b0;
            r_count      <= '0;
            r_sent       <= '0;
            r_pos        <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            // The timer restarts on every state change, so each LOW and GAP
            // phase begins counting from zero.
            if (w_next_state != r_state) begin
                r_timer <= '0;
            end else if ((r_state == S_LOW) || (r_state == S_GAP)) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_accept) begin
                r_dir   <= bus.cmd_dir;
                r_count <= bus.cmd_count;
                r_sent  <= '0;
            end else if (w_low_end) begin
                // Counted on the rising edge of the line, where the receiver
                // counts; pos wraps naturally at 2^CNT_W.
                r_sent <= r_sent + CNT_W'(1);
                r_pos  <= r_dir ? (r_pos + CNT_W'(1)) : (r_pos - CNT_W'(1));
            end

            if (r_state == S_FIN) begin
                r_abort_pend <= 1'b0;
            end else if (((r_state == S_LOW) || (r_state == S_GAP)) && bus.abort) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs, decoded from the next state so they change exactly
    // with the state and never glitch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_up        <= 1'b1;
            r_down      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_up        <= ~((w_next_state == S_LOW) &&  w_dir_eff);
            r_down      <= ~((w_next_state == S_LOW) && !w_dir_eff);
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_FIN);
            r_cmd_ready <= (w_next_state == S_IDLE);
        end
    end

    assign bus.up        = r_up;
    assign bus.down      = r_down;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.sent      = r_sent;
    assign bus.pos       = r_pos;

endmodule

// File: tb/tb_updown_pulse_tx.sv
// ----------------------------------------------------------------------------
// tb_updown_pulse_tx
// Directed bench for updown_pulse_tx with CNT_W=14, PULSE_LOW=4, PULSE_GAP=4.
// A receiver model counts rising edges of `up` and `down`; a line monitor
// measures pulse widths, gaps and overlaps on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_updown_pulse_tx;

    localparam int CNT_W    = 14;
    localparam int PL       = 4;
    localparam int PG       = 4;
    localparam int MAX_WAIT = 2000;

    logic clk;
    logic reset;

    updown_pulse_tx_if #(.CNT_W(CNT_W)) tx ();

    updown_pulse_tx #(
        .CNT_W     (CNT_W),
        .PULSE_LOW (PL),
        .PULSE_GAP (PG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tx.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Receiver model: counts on the rising edge of each line
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] rx_up;
    logic [CNT_W-1:0] rx_dn;
    logic [CNT_W-1:0] rx_out;

    always @(posedge tx.up or posedge reset) begin
        if (reset) rx_up <= '0;
        else       rx_up <= rx_up + CNT_W'(1);
    end

    always @(posedge tx.down or posedge reset) begin
        if (reset) rx_dn <= '0;
        else       rx_dn <= rx_dn + CNT_W'(1);
    end

    assign rx_out = rx_up - rx_dn;

    // ------------------------------------------------------------------------
    // Line monitor (monotonic counters; the sequence compares deltas)
    // ------------------------------------------------------------------------
    int   m_up_falls;
    int   m_dn_falls;
    int   m_both_low;
    int   m_bad_width;
    int   m_short_gap;
    int   m_high_at_fall;
    int   low_run;
    int   high_run;
    logic prev_up;
    logic prev_dn;

    always @(negedge clk) begin
        if (reset) begin
            low_run  = 0;
            high_run = 1000;
            prev_up  = 1'b1;
            prev_dn  = 1'b1;
        end else begin
            if (!tx.up && !tx.down) m_both_low++;
            if (prev_up && !tx.up)  m_up_falls++;
            if (prev_dn && !tx.down) m_dn_falls++;
            if (!tx.up || !tx.down) begin
                if (low_run == 0) begin
                    m_high_at_fall = high_run;
                    if (high_run < PG) m_short_gap++;
                end
                low_run++;
                high_run = 0;
            end else begin
                if (low_run != 0 && low_run != PL) m_bad_width++;
                low_run = 0;
                high_run++;
            end
            prev_up = tx.up;
            prev_dn = tx.down;
        end
    end

    int b_up, b_dn, b_both, b_width, b_gap;

    task automatic snap_base();
        b_up    = m_up_falls;
        b_dn    = m_dn_falls;
        b_both  = m_both_low;
        b_width = m_bad_width;
        b_gap   = m_short_gap;
    endtask

    task automatic check_lines(input string tag, input int exp_up, input int exp_dn);
        check({tag, "_up_pulses"}, 32'(m_up_falls - b_up), 32'(exp_up));
        check({tag, "_dn_pulses"}, 32'(m_dn_falls - b_dn), 32'(exp_dn));
        check({tag, "_both_low"},  32'(m_both_low - b_both), 32'd0);
        check({tag, "_bad_width"}, 32'(m_bad_width - b_width), 32'd0);
        check({tag, "_short_gap"}, 32'(m_short_gap - b_gap), 32'd0);
    endtask

    // Issue one command at a falling edge and wait for `done`. lat counts
    // falling edges from the acceptance edge, so a command of N pulses should
    // give N*(PL+PG)+1. abort_at is the cycle index after acceptance (cycle 0
    // is the one right after the accepting edge) in which abort is held high.
    task automatic run_cmd(input string tag, input logic dir, input int count,
                           input int abort_at, output int lat);
        bit got;
        check({tag, "_ready"}, 32'(tx.cmd_ready), 32'd1);
        tx.cmd_valid = 1'b1;
        tx.cmd_dir   = dir;
        tx.cmd_count = CNT_W'(count);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= MAX_WAIT && !got; i++) begin
            @(negedge clk);
            tx.cmd_valid = 1'b0;
            tx.abort     = ((i - 1) == abort_at);
            if (i == 1) begin
                check({tag, "_busy"}, 32'(tx.busy), 32'd1);
                check({tag, "_not_ready"}, 32'(tx.cmd_ready), 32'd0);
            end
            if (tx.done) begin
                got = 1'b1;
                lat = i;
            end
        end
        tx.abort = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        // let the line settle in IDLE before reading monitor counters
        repeat (2) @(negedge clk);
        check({tag, "_idle_busy"}, 32'(tx.busy), 32'd0);
    endtask

    int lat;
    int lat_a;
    int lat_b;
    int ready_viol;
    bit got;

    initial begin
        #500_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        tx.cmd_valid = 1'b0;
        tx.cmd_dir   = 1'b0;
        tx.cmd_count = '0;
        tx.abort     = 1'b0;
        reset        = 1'b0;
        #1 reset     = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_up",   32'(tx.up),   32'd1);
        check("rst_down", 32'(tx.down), 32'd1);
        check("rst_busy", 32'(tx.busy), 32'd0);
        check("rst_done", 32'(tx.done), 32'd0);
        check("rst_sent", 32'(tx.sent), 32'd0);
        check("rst_pos",  32'(tx.pos),  32'd0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(tx.cmd_ready), 32'd1);

        // ---------------- 1: up x3 ----------------
        snap_base();
        run_cmd("t1", 1'b1, 3, -1, lat);
        check("t1_latency", 32'(lat), 32'd25);
        check("t1_sent", 32'(tx.sent), 32'd3);
        check("t1_pos",  32'(tx.pos),  32'd3);
        check("t1_rx",   32'(rx_out),  32'd3);
        check_lines("t1", 3, 0);

        // ---------------- 2: down x5, wraps below zero ----------------
        snap_base();
        run_cmd("t2", 1'b0, 5, -1, lat);
        check("t2_latency", 32'(lat), 32'd41);
        check("t2_sent", 32'(tx.sent), 32'd5);
        check("t2_pos",  32'(tx.pos),  32'd16382);
        check("t2_rx",   32'(rx_out),  32'd16382);
        check_lines("t2", 0, 5);

        // ---------------- 3: zero-length command ----------------
        snap_base();
        run_cmd("t3", 1'b1, 0, -1, lat);
        check("t3_latency", 32'(lat), 32'd1);
        check("t3_sent", 32'(tx.sent), 32'd0);
        check("t3_pos",  32'(tx.pos),  32'd16382);
        check_lines("t3", 0, 0);

        // ---------------- 4: abort in 2nd low cycle of pulse 4 ----------------
        // pulse 4 is low in cycles 24..27; abort held in cycle 25
        snap_base();
        run_cmd("t4", 1'b1, 10, 25, lat);
        check("t4_latency", 32'(lat), 32'd33);
        check("t4_sent", 32'(tx.sent), 32'd4);
        check("t4_pos",  32'(tx.pos),  32'd2);
        check("t4_rx",   32'(rx_out),  32'd2);
        check_lines("t4", 4, 0);

        // ---------------- 5: abort in IDLE ignored; held second command ----------------
        tx.abort = 1'b1;
        @(negedge clk);
        tx.abort = 1'b0;
        snap_base();
        tx.cmd_valid = 1'b1;
        tx.cmd_dir   = 1'b1;
        tx.cmd_count = CNT_W'(2);
        @(negedge clk);
        check("t5_a_busy", 32'(tx.busy), 32'd1);
        // second command offered and held while the first runs
        tx.cmd_dir   = 1'b0;
        tx.cmd_count = CNT_W'(1);
        ready_viol   = 0;
        got          = 1'b0;
        lat_a        = 1;
        for (int i = 0; i < MAX_WAIT && !got; i++) begin
            if (tx.cmd_ready) ready_viol++;
            if (tx.done) got = 1'b1;
            else begin
                @(negedge clk);
                lat_a++;
            end
        end
        check("t5_a_done_seen", 32'(got), 32'd1);
        check("t5_ready_while_busy", 32'(ready_viol), 32'd0);
        check("t5_a_latency", 32'(lat_a), 32'd17);
        check("t5_a_sent", 32'(tx.sent), 32'd2);
        @(negedge clk);
        check("t5_idle_ready", 32'(tx.cmd_ready), 32'd1);
        check("t5_idle_busy",  32'(tx.busy), 32'd0);
        @(negedge clk);
        check("t5_b_busy",  32'(tx.busy), 32'd1);
        check("t5_b_ready", 32'(tx.cmd_ready), 32'd0);
        tx.cmd_valid = 1'b0;
        got   = 1'b0;
        lat_b = 1;
        for (int i = 0; i < MAX_WAIT && !got; i++) begin
            if (tx.done) got = 1'b1;
            else begin
                @(negedge clk);
                lat_b++;
            end
        end
        check("t5_b_done_seen", 32'(got), 32'd1);
        check("t5_b_latency", 32'(lat_b), 32'd9);
        repeat (2) @(negedge clk);
        check("t5_sent", 32'(tx.sent), 32'd1);
        check("t5_pos",  32'(tx.pos),  32'd3);
        check("t5_rx",   32'(rx_out),  32'd3);
        check("t5_high_between_cmds", 32'(m_high_at_fall), 32'd6);
        check_lines("t5", 2, 1);

        // ---------------- 6: reset mid LOW phase ----------------
        tx.cmd_valid = 1'b1;
        tx.cmd_dir   = 1'b1;
        tx.cmd_count = CNT_W'(5);
        @(negedge clk);
        tx.cmd_valid = 1'b0;
        check("t6_low_before_rst", 32'(tx.up), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_up",   32'(tx.up),   32'd1);
        check("t6_rst_down", 32'(tx.down), 32'd1);
        check("t6_rst_busy", 32'(tx.busy), 32'd0);
        check("t6_rst_pos",  32'(tx.pos),  32'd0);
        check("t6_rst_sent", 32'(tx.sent), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("t6_rel_ready", 32'(tx.cmd_ready), 32'd1);
        snap_base();
        run_cmd("t6", 1'b0, 2, -1, lat);
        check("t6_latency", 32'(lat), 32'd17);
        check("t6_sent", 32'(tx.sent), 32'd2);
        check("t6_pos",  32'(tx.pos),  32'd16382);
        check("t6_rx",   32'(rx_out),  32'd16382);
        check_lines("t6", 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_pulse_tx.md
Name: updown_pulse_tx

Overview:
Transmit end of the two-wire up/down pulse interface used by the 14-bit up/down score counter. It accepts a command of N steps and a direction, then emits N clean active-low pulses on `up` or `down`. Each pulse has a programmable low width and a programmable high gap. It also keeps a shadow position that mirrors the receiving counter's value, so the game logic and the bench can check both ends agree.

Parameters:
CNT_W, 14, width of step count, sent count and shadow position
PULSE_LOW, 4, clock cycles a line is held low per pulse (>=1)
PULSE_GAP, 4, clock cycles both lines are held high after each pulse (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_dir  input  1  1 = count up (pulse `up`), 0 = count down (pulse `down`)
cmd_count  input  CNT_W  number of pulses to send
abort  input  1  stop after the pulse in progress
up  output  1  active-low up pulse line, idle high
down  output  1  active-low down pulse line, idle high
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle strobe when a command finishes or aborts
sent  output  CNT_W  pulses completed for the current or last command
pos  output  CNT_W  shadow of receiver count, modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, active-high) sets the following, taking effect immediately:
  - state = IDLE; `up` = 1, `down` = 1.
  - `cmd_ready` = 1 once reset is released; `busy` = 0, `done` = 0, `sent` = 0, `pos` = 0.
  - A pulse cut short by reset is not guaranteed to be counted by the receiver. The team resets both ends together.
- States are IDLE, LOW, GAP, FIN.
- IDLE:
  - `cmd_ready` = 1. On `cmd_valid` & `cmd_ready`, latch `cmd_dir` and `cmd_count`, and clear `sent`.
  - If `cmd_count` == 0: go to FIN; no pulse is emitted.
  - Otherwise: go to LOW.
- LOW:
  - The selected line is driven 0 from the cycle after acceptance, for exactly PULSE_LOW cycles.
  - The other line stays 1.
  - `up` and `down` are never low in the same cycle.
  - Then go to GAP.
  - `sent` and `pos` update on the LOW->GAP edge, i.e. on the rising edge of the line, where the receiver counts: `sent` += 1; `pos` += 1 if dir = 1, else `pos` -= 1.
- GAP:
  - Both lines are 1 for exactly PULSE_GAP cycles.
  - If `sent` == latched count, or abort is pending: go to FIN.
  - Otherwise: go to LOW.
- FIN: `done` = 1 for one cycle, then go to IDLE. `sent` holds its value until the next accepted command.
- Abort:
  - Sampled in LOW or GAP; it sets a pending flag.
  - The pulse in progress always completes its full low width and the gap that follows.
  - No further pulse starts.
  - Abort in IDLE or FIN is ignored. The pending flag clears in FIN.
- Pulse period is PULSE_LOW + PULSE_GAP cycles.
- Command latency is N·(PULSE_LOW + PULSE_GAP) + 1 cycles from acceptance to `done`.
- `pos` wraps modulo 2^CNT_W:
  - 16383 + 1 -> 0.
  - 0 - 1 -> 16383.
- `cmd_valid` while busy is not accepted (`cmd_ready` = 0); the command must be held by the sender.
- Outputs `up`, `down`, `busy`, `done` and `cmd_ready` are registered (glitch-free), since the receiver is edge-triggered on `up` and `down`.
- Back-to-back commands: a new command may be accepted in the IDLE cycle after FIN. The minimum high time between pulses of consecutive commands is PULSE_GAP + 2 cycles.

Test Plan:
1. Reset, then command dir=1, count=3 (defaults) -> three 4-cycle low pulses on `up`, 4-cycle gaps, `down` constant 1; `done` 25 cycles after acceptance; `sent`=3, `pos`=3; receiver model `out`=3.
2. From `pos`=3, command dir=0, count=5 -> five pulses on `down`; `pos` wraps to 16382; receiver `out`=16382; `up` never low.
3. Command count=0 -> no line activity, `done` on the cycle after acceptance, `sent`=0, `pos` unchanged.
4. Command dir=1, count=10; assert abort during the 2nd cycle of pulse 4's low phase -> pulse 4 completes its full 4 low cycles plus gap; `done`; `sent`=4, `pos` += 4; no 5th pulse.
5. Hold `cmd_valid` with a second command while busy -> `cmd_ready`=0 throughout, second command accepted in the cycle after `done`; check minimum high time between commands is 6 cycles.
6. Assert reset in the middle of a LOW phase -> `up`/`down` go to 1 immediately (asynchronously), `pos`=0, `sent`=0, `busy`=0; a new command after release runs normally.
